vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  Sequences VGA 640x480@60 raster timing in the system clock domain, advancing one pixel per pix_en_i strobe.
//  pix_en_i is the one-cycle pixel enable derived from the pixel clock divider/PLL.
//  Generates sync/DE/coordinates, gates start-up on clock lock and prefetches each visible line from the framebuffer.
//  Uses a req/ack handshake for the prefetch and flags underruns.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   hsync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync width (lines)
//  V_BP       33   vertical back porch (lines)
//  HSYNC_POL  0    hsync active level
//  VSYNC_POL  0    vsync active level
//  Derived: H_TOTAL=800, V_TOTAL=525, XW=$clog2(H_TOTAL), YW=$clog2(V_TOTAL)
// PORTS
//  clk_i          in   1   system clock (only clock)
//  rst_ni         in   1   asynchronous, active-low reset
//  enable_i       in   1   run request (level)
//  locked_i       in   1   pixel clock source locked
//  pix_en_i       in   1   pixel strobe, one clk_i cycle wide
//  hsync_o        out  1   horizontal sync
//  vsync_o        out  1   vertical sync
//  de_o           out  1   display enable (visible pixel)
//  x_o            out  XW  current h count
//  y_o            out  YW  current v count
//  frame_start_o  out  1   1-clk pulse on entry to (0,0)
//  line_req_o     out  1   line prefetch request (level)
//  line_req_y_o   out  YW  line number requested
//  line_ack_i     in   1   prefetch accepted/done
//  underrun_o     out  1   sticky: line not acked in time
//  err_clr_i      in   1   clears underrun_o
//  busy_o         out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset values: all outputs 0, except hsync_o=~HSYNC_POL and vsync_o=~VSYNC_POL. Counters h=0, v=V_ACTIVE; FSM=IDLE.
//  - FSM states: IDLE, WAIT_LOCK, RUN.
//    - IDLE -> WAIT_LOCK when enable_i=1.
//    - WAIT_LOCK -> RUN on the first cycle with locked_i=1.
//    - RUN -> WAIT_LOCK immediately when locked_i=0.
//    - RUN -> IDLE when enable_i=0 at the frame-wrap strobe: the current frame always completes, and the (0,0) step is not taken.
//  - Outside RUN:
//    - Counters are forced to h=0, v=V_ACTIVE; pix_en_i is ignored.
//    - Syncs inactive; de_o, line_req_o and frame_start_o are 0; pending request dropped.
//  - Entry at v=V_ACTIVE gives a full vertical blank in which line 0 is prefetched.
//  - RUN counting, on a pix_en_i cycle only:
//    - h wraps at H_TOTAL-1 to 0.
//    - v increments on h wrap and wraps at V_TOTAL-1 to 0.
//  - Outputs are registered and change on the same edge as the counters (decode of next count); latency 0 vs counters.
//    - x_o=h, y_o=v.
//    - de_o = (h<H_ACTIVE)&&(v<V_ACTIVE).
//    - hsync_o=HSYNC_POL when h in [656,752); vsync_o=VSYNC_POL when v in [490,492).
//  - frame_start_o pulses for exactly one clk on the edge where the counters become (0,0).
//  - Prefetch request:
//    - Issue: on the strobe where h becomes H_ACTIVE, with nv=(v+1) mod V_TOTAL. If nv<V_ACTIVE, set line_req_o=1 and line_req_y_o=nv.
//    - Retire: line_req_o stays high until a cycle with line_ack_i=1; it clears on the next edge.
//    - line_ack_i while line_req_o=0 is ignored. Ack in the same cycle the request is issued is not possible: the request is visible one cycle later.
//  - Underrun:
//    - Trigger: line_req_o is still 1 on the strobe where h wraps to 0 into a visible line.
//    - Response: set underrun_o and drop the request. Output continues undisturbed.
//    - Clear: err_clr_i clears underrun_o; a set in the same cycle wins.
//  - Async reset mid-frame restores all reset values immediately, independent of clk_i.
// TESTING
//  1. Reset, enable=1, locked=1, pix_en every 4th clk -> frame_start_o after 45*800 strobes (144000 clks); busy_o=1.
//  2. One full frame -> 307200 de_o strobes; per line hsync low at x=656..751; vsync low on y=490,491; 800 strobes/line.
//  3. Ack 3 clks after each req -> line_req_y_o=0 issued at (640,524), then 1 at (640,0), ..., 479 at (640,478); underrun_o stays 0.
//  4. Never ack -> underrun_o=1 at the (0,0) strobe; req dropped; err_clr_i pulse -> 0 next clk; err_clr and set together -> stays 1.
//  5. Drop locked_i at (100,200) -> next edge: de_o=0, syncs inactive, x/y=(0,480); relock -> RUN resumes from (0,480).
//  6. enable_i=0 at (300,100) -> frame completes, IDLE at wrap, no frame_start_o. rst_ni low mid-line -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing sequencer: advances one pixel per pix_en_i strobe, gates
// start-up on clock lock, prefetches each visible line via req/ack and flags
// lines that were not delivered in time.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW       = $clog2(H_TOTAL),
  localparam int unsigned YW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          locked_i,
  input  logic          pix_en_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_start_o,
  output logic          line_req_o,
  output logic [YW-1:0] line_req_y_o,
  input  logic          line_ack_i,
  output logic          underrun_o,
  input  logic          err_clr_i,
  output logic          busy_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;

  localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_C   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_FIRST  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_C   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_FIRST  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [1:0]    r_state, w_state_nx;
  logic [XW-1:0] r_h, w_h_nx;
  logic [YW-1:0] r_v, w_v_nx;
  logic [YW-1:0] r_y;
  logic          r_hs, r_vs, r_de, r_fs, r_busy;
  logic          r_req, w_req_nx;
  logic [YW-1:0] r_req_y, w_req_y_nx;
  logic          r_und;
  logic          w_step, w_fs_nx, w_und_set, w_run_nx;
  logic          w_de_nx, w_hs_nx, w_vs_nx;
  logic [YW-1:0] w_line;

  // Next state, next counters, prefetch request and output decode of next count
  always_comb begin
    w_state_nx = r_state;
    w_h_nx     = r_h;
    w_v_nx     = r_v;
    w_step     = 1'b0;
    w_fs_nx    = 1'b0;
    w_req_nx   = r_req;
    w_req_y_nx = r_req_y;
    w_und_set  = 1'b0;
    w_line     = '0;

    case (r_state)
      S_IDLE:      if (enable_i) w_state_nx = S_WAIT_LOCK;
      S_WAIT_LOCK: if (locked_i) w_state_nx = S_RUN;
      S_RUN: begin
        if (!locked_i) begin
          w_state_nx = S_WAIT_LOCK;
        end else if (pix_en_i && r_h == H_LAST && r_v == V_LAST && !enable_i) begin
          // Frame finished with no run request: stop instead of stepping to (0,0)
          w_state_nx = S_IDLE;
        end else if (pix_en_i) begin
          w_step = 1'b1;
        end
      end
      default:     w_state_nx = S_IDLE;
    endcase

    w_run_nx = (w_state_nx == S_RUN);

    if (!w_run_nx) begin
      w_h_nx   = '0;
      w_v_nx   = V_ACT_C;
      w_req_nx = 1'b0;
    end else begin
      if (r_req && line_ack_i) w_req_nx = 1'b0;
      if (w_step) begin
        if (r_h == H_LAST) begin
          w_h_nx = '0;
          w_v_nx = (r_v == V_LAST) ? '0 : r_v + YW'(1);
        end else begin
          w_h_nx = r_h + XW'(1);
        end
        w_fs_nx = (w_h_nx == '0) && (w_v_nx == '0);
        // Entering a visible line while its prefetch is still outstanding
        if (w_h_nx == '0 && w_v_nx < V_ACT_C && r_req) begin
          w_und_set = 1'b1;
          w_req_nx  = 1'b0;
        end
        // Start of horizontal blank: ask for the next line if it is visible
        if (w_h_nx == H_ACT_C) begin
          w_line = (r_v == V_LAST) ? '0 : r_v + YW'(1);
          if (w_line < V_ACT_C) begin
            w_req_nx   = 1'b1;
            w_req_y_nx = w_line;
          end
        end
      end
    end

    w_de_nx = w_run_nx && (w_h_nx < H_ACT_C) && (w_v_nx < V_ACT_C);
    w_hs_nx = (w_run_nx && w_h_nx >= HS_FIRST && w_h_nx <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
    w_vs_nx = (w_run_nx && w_v_nx >= VS_FIRST && w_v_nx <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= V_ACT_C;
      r_y     <= '0;
      r_hs    <= ~HSYNC_POL;
      r_vs    <= ~VSYNC_POL;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_req   <= 1'b0;
      r_req_y <= '0;
      r_und   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_h     <= w_h_nx;
      r_v     <= w_v_nx;
      r_y     <= w_v_nx;
      r_hs    <= w_hs_nx;
      r_vs    <= w_vs_nx;
      r_de    <= w_de_nx;
      r_fs    <= w_fs_nx;
      r_req   <= w_req_nx;
      r_req_y <= w_req_y_nx;
      r_und   <= w_und_set | (r_und & ~err_clr_i);
      r_busy  <= (w_state_nx != S_IDLE);
    end
  end

  assign hsync_o       = r_hs;
  assign vsync_o       = r_vs;
  assign de_o          = r_de;
  assign x_o           = r_h;
  assign y_o           = r_y;
  assign frame_start_o = r_fs;
  assign line_req_o    = r_req;
  assign line_req_y_o  = r_req_y;
  assign underrun_o    = r_und;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl using a shrunk raster (25x15) so whole frames fit
// in a short run; a linear-pixel-index model predicts every output each cycle.
module tb_vga_timing_ctrl;

  localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;
  localparam int P0 = VA * HT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b0, locked_i = 1'b0, pix_en_i = 1'b0;
  logic          line_ack_i = 1'b0, err_clr_i = 1'b0;
  logic          hsync_o, vsync_o, de_o, frame_start_o, line_req_o, underrun_o, busy_o;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o, line_req_y_o;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .locked_i(locked_i),
    .pix_en_i(pix_en_i), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .x_o(x_o), .y_o(y_o), .frame_start_o(frame_start_o), .line_req_o(line_req_o),
    .line_req_y_o(line_req_y_o), .line_ack_i(line_ack_i), .underrun_o(underrun_o),
    .err_clr_i(err_clr_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=waiting for lock 2=running; p = linear pixel index
  int m_mode, m_p, m_req, m_req_y, m_und, m_fs, m_step, m_fresh;

  task automatic m_reset();
    m_mode = 0; m_p = P0; m_req = 0; m_req_y = 0;
    m_und = 0; m_fs = 0; m_step = 0; m_fresh = 1;
  endtask

  task automatic m_advance();
    int h, v, old_req, set;
    m_step = 0; m_fs = 0; m_fresh = 0; set = 0;
    old_req = m_req;
    if (m_mode == 0) begin
      m_req = 0;
      if (enable_i) m_mode = 1;
    end else if (m_mode == 1) begin
      m_req = 0;
      if (locked_i) m_mode = 2;
    end else if (!locked_i) begin
      m_mode = 1; m_req = 0; m_p = P0;
    end else begin
      if (old_req != 0 && line_ack_i) m_req = 0;
      if (pix_en_i) begin
        if (m_p == FR - 1 && !enable_i) begin
          m_mode = 0; m_req = 0; m_p = P0;
        end else begin
          m_p = (m_p + 1) % FR;
          m_step = 1;
          h = m_p % HT;
          v = m_p / HT;
          if (m_p == 0) m_fs = 1;
          if (h == 0 && v < VA && old_req != 0) begin set = 1; m_req = 0; end
          if (h == HA && ((v + 1) % VT) < VA) begin m_req = 1; m_req_y = (v + 1) % VT; end
        end
      end
    end
    m_und = (set != 0 || (m_und != 0 && !err_clr_i)) ? 1 : 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) m_reset();
      else m_advance();
    end
  end

  // Per-cycle comparison plus frame statistics taken from the DUT outputs
  int strobe_total = 0, first_fs_at = -1, fs_count = 0;
  int cnt_st = 0, cnt_strb = 0, cnt_de = 0, cnt_hs = 0, cnt_vs = 0;

  initial begin
    forever begin
      int h, v, run;
      @(negedge clk_i);
      run = (m_mode == 2) ? 1 : 0;
      h = m_p % HT;
      v = m_p / HT;
      chk("x", int'(x_o), h);
      chk("y", int'(y_o), (m_fresh != 0) ? 0 : v);
      chk("de", int'(de_o), (run != 0 && h < HA && v < VA) ? 1 : 0);
      chk("hsync", int'(hsync_o), (run != 0 && h >= HA + HFP && h < HA + HFP + HSW) ? 0 : 1);
      chk("vsync", int'(vsync_o), (run != 0 && v >= VA + VFP && v < VA + VFP + VSW) ? 0 : 1);
      chk("frame_start", int'(frame_start_o), m_fs);
      chk("line_req", int'(line_req_o), m_req);
      if (m_req != 0) chk("line_req_y", int'(line_req_y_o), m_req_y);
      chk("underrun", int'(underrun_o), m_und);
      chk("busy", int'(busy_o), (m_mode != 0) ? 1 : 0);

      if (m_step != 0) strobe_total++;
      if (frame_start_o && first_fs_at < 0) first_fs_at = strobe_total;
      if (frame_start_o) fs_count++;
      if (m_step != 0) begin
        if (frame_start_o && cnt_st == 1) begin
          cnt_st = 2; cnt_strb = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
        end else if (frame_start_o && cnt_st == 2) begin
          cnt_st = 3;
        end
        if (cnt_st == 2) begin
          cnt_strb++;
          if (de_o) cnt_de++;
          if (!hsync_o) cnt_hs++;
          if (!vsync_o) cnt_vs++;
        end
      end
    end
  end

  // Stimulus: pix_mode 0=every 4th clk, 1=random, 2=off; ack_mode 0=never, 1=fixed, 2=random
  int pix_mode = 0, ack_mode = 0, ack_dly = 2, wait_cnt = 0, err_mode = 0, cyc = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
    case (pix_mode)
      0:       pix_en_i = (cyc % 4 == 0);
      1:       pix_en_i = ($urandom % 2 == 0);
      default: pix_en_i = 1'b0;
    endcase
    cyc++;
    if (line_ack_i) begin
      line_ack_i = 1'b0;
    end else if (line_req_o && ack_mode != 0) begin
      if (wait_cnt == 0 && ack_mode == 2) ack_dly = $urandom_range(0, 24);
      if (wait_cnt >= ack_dly) begin line_ack_i = 1'b1; wait_cnt = 0; end
      else wait_cnt++;
    end else begin
      wait_cnt = 0;
      if (ack_mode == 2) line_ack_i = ($urandom % 8 == 0);
    end
    case (err_mode)
      1:       err_clr_i = ($urandom % 8 == 0);
      2:       err_clr_i = 1'b1;
      default: err_clr_i = 1'b0;
    endcase
  endtask

  initial begin
    int n, fs_before;

    // Reset values while reset is held
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_hsync", int'(hsync_o), 1);
    chk("rst_vsync", int'(vsync_o), 1);
    chk("rst_y", int'(y_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    rst_ni = 1'b1;

    // Start-up: strobes from RUN entry to the first (0,0)
    enable_i = 1'b1; locked_i = 1'b1; pix_mode = 0; ack_mode = 1; ack_dly = 2;
    n = 0;
    while (!frame_start_o && n < 2000) begin tick(); @(negedge clk_i); #1; n++; end
    chk("first_frame_timeout", (n < 2000) ? 1 : 0, 1);
    chk("first_frame_strobes", first_fs_at, (VT - VA) * HT);
    chk("busy_running", int'(busy_o), 1);

    // One full frame statistics
    pix_mode = 1;
    cnt_st = 1;
    n = 0;
    while (cnt_st != 3 && n < 3000) begin tick(); @(negedge clk_i); #1; n++; end
    chk("frame_stats_timeout", (n < 3000) ? 1 : 0, 1);
    chk("frame_strobes", cnt_strb, 375);
    chk("frame_de", cnt_de, 128);
    chk("frame_hsync_low", cnt_hs, 60);
    chk("frame_vsync_low", cnt_vs, 50);
    chk("no_underrun_with_ack", int'(underrun_o), 0);

    // Random ack timing, spurious acks and error clears
    ack_mode = 2; err_mode = 1;
    repeat (3000) tick();

    // Never ack: underrun must appear and the request be dropped
    ack_mode = 0; err_mode = 2;
    tick();
    err_mode = 0;
    n = 0;
    while (!underrun_o && n < 2000) begin tick(); @(negedge clk_i); #1; n++; end
    chk("underrun_timeout", (n < 2000) ? 1 : 0, 1);
    chk("underrun_set", int'(underrun_o), 1);
    chk("underrun_req_dropped", int'(line_req_o), 0);

    // Clear with no strobes pending
    pix_mode = 2; err_mode = 2;
    tick();
    err_mode = 0;
    tick();
    @(negedge clk_i); #1;
    chk("underrun_cleared", int'(underrun_o), 0);

    // Lock loss mid-frame
    pix_mode = 1; ack_mode = 1; ack_dly = 2;
    n = 0;
    while (!(x_o == XW'(10) && y_o == YW'(5)) && n < 3000) begin tick(); @(negedge clk_i); #1; n++; end
    chk("lock_pos_timeout", (n < 3000) ? 1 : 0, 1);
    locked_i = 1'b0;
    @(negedge clk_i); #1;
    chk("unlock_x", int'(x_o), 0);
    chk("unlock_y", int'(y_o), VA);
    chk("unlock_de", int'(de_o), 0);
    chk("unlock_hsync", int'(hsync_o), 1);
    chk("unlock_busy", int'(busy_o), 1);
    repeat (5) tick();
    locked_i = 1'b1;
    n = 0;
    while (!frame_start_o && n < 2000) begin tick(); @(negedge clk_i); #1; n++; end
    chk("relock_frame_timeout", (n < 2000) ? 1 : 0, 1);

    // Disable mid-frame: frame completes, no new frame start
    n = 0;
    while (!(x_o == XW'(3) && y_o == YW'(4)) && n < 3000) begin tick(); @(negedge clk_i); #1; n++; end
    chk("disable_pos_timeout", (n < 3000) ? 1 : 0, 1);
    enable_i = 1'b0;
    fs_before = fs_count;
    n = 0;
    while (busy_o && n < 3000) begin tick(); @(negedge clk_i); #1; n++; end
    chk("idle_timeout", (n < 3000) ? 1 : 0, 1);
    chk("idle_no_frame_start", fs_count, fs_before);
    chk("idle_y", int'(y_o), VA);
    chk("idle_x", int'(x_o), 0);

    // Async reset in the middle of a line
    enable_i = 1'b1;
    n = 0;
    while (!(x_o == XW'(5) && y_o == YW'(2)) && n < 3000) begin tick(); @(negedge clk_i); #1; n++; end
    chk("reset_pos_timeout", (n < 3000) ? 1 : 0, 1);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_hsync", int'(hsync_o), 1);
    chk("arst_vsync", int'(vsync_o), 1);
    chk("arst_x", int'(x_o), 0);
    chk("arst_y", int'(y_o), 0);
    chk("arst_de", int'(de_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_req", int'(line_req_o), 0);
    repeat (2) @(negedge clk_i);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
